// File: rtl/note_draw_scheduler.sv
// Frame scheduler for the note-block plot engine: each frame runs an erase pass and then a draw
// pass over the note slots, handing one slot at a time to the plotter over valid/ready.
module note_draw_scheduler #(
  parameter int unsigned NUM_SLOTS    = 15,
  parameter int unsigned FRAME_WAIT   = 19201,
  parameter int unsigned DONE_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 17
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] slot_enable_i,
  input  logic                 cmd_ready_i,
  input  logic                 plot_done_i,
  output logic [3:0]           command_o,
  output logic                 cmd_erase_o,
  output logic                 cmd_valid_o,
  output logic                 frame_tick_o,
  output logic                 busy_o,
  output logic                 err_timeout_o
);

  typedef enum logic [1:0] {StWait, StScan, StIssue, StWaitDone} state_e;

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(FRAME_WAIT - 1);
  localparam logic [CNT_W-1:0] DoneLast = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [3:0]       EndPtr   = 4'(NUM_SLOTS);
  localparam logic [3:0]       NoCmd    = 4'hF;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           ptr_q;
  logic                 erase_phase_q;
  logic [NUM_SLOTS-1:0] erase_mask_q;
  logic [NUM_SLOTS-1:0] draw_mask_q;
  logic [3:0]           command_q;
  logic                 cmd_erase_q;
  logic                 cmd_valid_q;
  logic                 frame_tick_q;
  logic                 busy_q;
  logic                 err_timeout_q;

  // Widened to 16 bits so the 4-bit pointer indexes it for any slot count.
  logic [15:0] act_mask;
  always_comb begin
    act_mask = erase_phase_q ? 16'(erase_mask_q) : 16'(draw_mask_q);
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q       <= StWait;
      cnt_q         <= '0;
      ptr_q         <= '0;
      erase_phase_q <= 1'b1;
      erase_mask_q  <= '0;
      draw_mask_q   <= '0;
      command_q     <= NoCmd;
      cmd_erase_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (cnt_q == WaitLast) begin
            cnt_q         <= '0;
            ptr_q         <= '0;
            erase_phase_q <= 1'b1;
            // Erase what was drawn last frame, then draw this frame's snapshot.
            erase_mask_q  <= draw_mask_q;
            draw_mask_q   <= slot_enable_i;
            state_q       <= StScan;
            busy_q        <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StScan: begin
          if (ptr_q == EndPtr) begin
            if (erase_phase_q) begin
              erase_phase_q <= 1'b0;
              ptr_q         <= '0;
            end else begin
              frame_tick_q <= 1'b1;
              cnt_q        <= '0;
              busy_q       <= 1'b0;
              state_q      <= StWait;
            end
          end else if (act_mask[ptr_q]) begin
            command_q   <= ptr_q;
            cmd_erase_q <= erase_phase_q;
            cmd_valid_q <= 1'b1;
            state_q     <= StIssue;
          end else begin
            ptr_q <= ptr_q + 4'd1;
          end
        end
        StIssue: begin
          if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (plot_done_i || (cnt_q == DoneLast)) begin
            if (!plot_done_i) begin
              err_timeout_q <= 1'b1;
            end
            ptr_q     <= ptr_q + 4'd1;
            command_q <= NoCmd;
            state_q   <= StScan;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign command_o     = command_q;
  assign cmd_erase_o   = cmd_erase_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign frame_tick_o  = frame_tick_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_note_draw_scheduler.sv
// Bench for note_draw_scheduler: frame table with a command scoreboard, plus hand sequences for
// ready stall, plot_done timeout and reset during WAIT_DONE.
module tb_note_draw_scheduler;

  logic        CLK;
  logic        reset;
  logic [14:0] slot_enable;
  logic        cmd_ready;
  logic        plot_done;
  logic [3:0]  command;
  logic        cmd_erase;
  logic        cmd_valid;
  logic        frame_tick;
  logic        busy;
  logic        err_timeout;

  note_draw_scheduler #(
    .NUM_SLOTS   (15),
    .FRAME_WAIT  (8),
    .DONE_TIMEOUT(4),
    .CNT_W       (17)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .slot_enable_i(slot_enable),
    .cmd_ready_i  (cmd_ready),
    .plot_done_i  (plot_done),
    .command_o    (command),
    .cmd_erase_o  (cmd_erase),
    .cmd_valid_o  (cmd_valid),
    .frame_tick_o (frame_tick),
    .busy_o       (busy),
    .err_timeout_o(err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [14:0] en;
    int          gap;
  } vec_t;

  typedef struct {
    logic [3:0] slot;
    logic       erase;
  } cmd_t;

  int   tests = 0;
  int   fails = 0;
  cmd_t exp_q[$];
  bit   manual = 1'b0;
  bit   man_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pass(input logic [14:0] m, input logic er);
    for (int i = 0; i < 15; i++) begin
      if (m[i]) exp_q.push_back('{slot: 4'(i), erase: er});
    end
  endtask

  // Counts cycles up to and including the next frame_tick sample.
  task automatic wait_tick(input bit junk, output int cyc, output int idle, output bit got);
    cyc  = 0;
    idle = 0;
    got  = 1'b0;
    while (cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (busy === 1'b0) idle++;
      if (junk && cyc == 12) slot_enable = 15'($urandom);
      if (frame_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL frame_tick_timeout: got no tick, expected one within 1000 cycles");
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (cmd_valid !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL cmd_valid_timeout: got no cmd_valid, expected one within 200 cycles");
    end
  endtask

  // Scoreboard: every new command (cmd_valid rising) must match the head of the queue.
  initial begin
    logic prev_valid = 1'b0;
    cmd_t e;
    forever begin
      @(negedge CLK);
      if (reset === 1'b1 && cmd_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd: got slot %0d erase %0b, expected no command",
                   command, cmd_erase);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_slot", 32'(command), 32'(e.slot));
          chk("cmd_erase", 32'(cmd_erase), 32'(e.erase));
        end
      end
      prev_valid = (cmd_valid === 1'b1);
    end
  end

  // Plotter model: ready at once, plot_done three cycles after acceptance.
  initial begin
    int dc = 0;
    cmd_ready = 1'b1;
    plot_done = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (manual) begin
        dc        = 0;
        plot_done = 1'b0;
        cmd_ready = man_ready;
      end else begin
        cmd_ready = 1'b1;
        plot_done = 1'b0;
        if (dc > 0) begin
          dc--;
          if (dc == 0) plot_done = 1'b1;
        end
        if (cmd_valid === 1'b1) dc = 3;
      end
    end
  end

  initial begin
    vec_t        tbl[9];
    logic [14:0] prev;
    int          cyc;
    int          idle;
    bit          got;

    tbl[0] = '{en: 15'h0000, gap: 40};
    tbl[1] = '{en: 15'h0000, gap: 40};
    tbl[2] = '{en: 15'h0005, gap: 48};
    tbl[3] = '{en: 15'h0005, gap: 56};
    tbl[4] = '{en: 15'h4001, gap: 56};
    tbl[5] = '{en: 15'h0000, gap: 48};
    tbl[6] = '{en: 15'h7FFF, gap: 100};
    tbl[7] = '{en: 15'h7FFF, gap: 160};
    tbl[8] = '{en: 15'h0000, gap: 100};

    reset       = 1'b0;
    slot_enable = '0;
    prev        = '0;
    repeat (3) @(negedge CLK);
    chk("rst_command", 32'(command), 32'hF);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);
    chk("rst_cmd_erase", 32'(cmd_erase), 32'h0);
    reset = 1'b1;

    // Each entry is the slot_enable seen at one WAIT exit; junk is driven mid-pass.
    for (int k = 0; k < 9; k++) begin
      slot_enable = tbl[k].en;
      push_pass(prev, 1'b1);
      push_pass(tbl[k].en, 1'b0);
      prev = tbl[k].en;
      wait_tick(1'b1, cyc, idle, got);
      chk($sformatf("frame%0d_period", k), 32'(cyc), 32'(tbl[k].gap));
      chk($sformatf("frame%0d_idle", k), 32'(idle), 32'd8);
    end

    // Ready stall for five cycles, then plot_done never arrives.
    man_ready   = 1'b0;
    manual      = 1'b1;
    slot_enable = 15'h0008;
    push_pass(15'h0008, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("stall%0d_valid", i), 32'(cmd_valid), 32'h1);
      chk($sformatf("stall%0d_command", i), 32'(command), 32'h3);
    end
    man_ready = 1'b1;
    @(negedge CLK);
    man_ready = 1'b0;
    chk("accept_valid_drop", 32'(cmd_valid), 32'h0);
    chk("accept_command_held", 32'(command), 32'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("wd%0d_err", i), 32'(err_timeout), 32'h0);
      chk($sformatf("wd%0d_command", i), 32'(command), 32'h3);
    end
    @(negedge CLK);
    chk("timeout_err", 32'(err_timeout), 32'h1);
    chk("timeout_command", 32'(command), 32'hF);
    chk("timeout_busy", 32'(busy), 32'h1);
    manual      = 1'b0;
    slot_enable = 15'h0000;
    push_pass(15'h0008, 1'b1);
    wait_tick(1'b0, cyc, idle, got);
    chk("timeout_err_sticky1", 32'(err_timeout), 32'h1);
    wait_tick(1'b0, cyc, idle, got);
    chk("erase_frame_period", 32'(cyc), 32'd44);
    chk("timeout_err_sticky2", 32'(err_timeout), 32'h1);

    // Reset while the plotter is working on slot 1.
    slot_enable = 15'h0002;
    push_pass(15'h0002, 1'b0);
    wait_valid();
    @(negedge CLK);
    reset  = 1'b0;
    manual = 1'b1;
    @(negedge CLK);
    chk("midreset_command", 32'(command), 32'hF);
    chk("midreset_valid", 32'(cmd_valid), 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_err", 32'(err_timeout), 32'h0);
    chk("midreset_tick", 32'(frame_tick), 32'h0);
    reset  = 1'b1;
    manual = 1'b0;
    push_pass(15'h0002, 1'b0);
    wait_tick(1'b0, cyc, idle, got);
    chk("postreset_period", 32'(cyc), 32'd44);
    chk("postreset_idle", 32'(idle), 32'd8);

    repeat (2) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
